alu_result_serializer: RTL and testbench

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

---
 rtl/alu_result_serializer.sv | 162 ++++++++++++++++
 tb/tb_alu_result_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Serializes one ALU result at a time into a byte stream: a header byte
// {4'hA, src, carry, 0} followed by the result payload, LSB byte first.
// Results arriving while a frame is in flight, or losing arbitration,
// are dropped and reported with a one-cycle Drop_Flag pulse.
//
// Ports
//   CLK, RST                  clock, synchronous active-low reset
//   Arith_OUT/Carry_OUT/Arith_Flag   arithmetic result, carry, valid (src 00)
//   Logic_OUT/Logic_Flag             logic result, valid            (src 01)
//   CMP_OUT/CMP_Flag                 compare result, valid          (src 10)
//   Shift_OUT/Shift_Flag             shift result, valid            (src 11)
//   TX_DATA/TX_VALID/TX_READY        byte stream to transmitter
//   Busy                             frame in progress
//   Drop_Flag                        a result was discarded last cycle
//
// state   | meaning
// IDLE    | waiting for a result flag
// HEADER  | presenting header byte
// PAYLOAD | presenting payload bytes, LSB first
module alu_result_serializer #(
    parameter int OP_DATA_WIDTH = 16,
    parameter int ARITH_WIDTH   = 2 * OP_DATA_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ARITH_WIDTH-1:0]   Arith_OUT,
    input  logic                     Carry_OUT,
    input  logic                     Arith_Flag,
    input  logic [OP_DATA_WIDTH-1:0] Logic_OUT,
    input  logic                     Logic_Flag,
    input  logic [OP_DATA_WIDTH-1:0] Shift_OUT,
    input  logic                     Shift_Flag,
    input  logic [2:0]               CMP_OUT,
    input  logic                     CMP_Flag,
    output logic [7:0]               TX_DATA,
    output logic                     TX_VALID,
    input  logic                     TX_READY,
    output logic                     Busy,
    output logic                     Drop_Flag
);

    localparam int CW = $clog2(ARITH_WIDTH / 8 + 1);
    localparam logic [CW-1:0] ARITH_LAST = CW'(ARITH_WIDTH / 8 - 1);
    localparam logic [CW-1:0] OP_LAST    = CW'(OP_DATA_WIDTH / 8 - 1);

    localparam logic [1:0] SRC_ARITH = 2'b00;
    localparam logic [1:0] SRC_LOGIC = 2'b01;
    localparam logic [1:0] SRC_CMP   = 2'b10;
    localparam logic [1:0] SRC_SHIFT = 2'b11;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             src_q, src_d;
    logic                   carry_q, carry_d;
    logic [ARITH_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   drop_q, drop_d;

    logic          any_flag;
    logic          multi_flag;
    logic          xfer;
    logic          last_xfer;
    logic          capture;
    logic [CW-1:0] last_idx;

    always_comb begin
        any_flag   = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
        multi_flag = (Arith_Flag & (Logic_Flag | CMP_Flag | Shift_Flag))
                   | (Logic_Flag & (CMP_Flag | Shift_Flag))
                   | (CMP_Flag & Shift_Flag);

        case (src_q)
            SRC_ARITH: last_idx = ARITH_LAST;
            SRC_CMP:   last_idx = '0;
            default:   last_idx = OP_LAST;
        endcase

        xfer      = TX_READY && (state_q != IDLE);
        last_xfer = xfer && (state_q == PAYLOAD) && (cnt_q == last_idx);
        // The edge that retires the last byte can also accept a new result.
        capture   = any_flag && ((state_q == IDLE) || last_xfer);

        state_d = state_q;
        src_d   = src_q;
        carry_d = carry_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // Any flag that is not captured is a dropped result.
        drop_d  = capture ? multi_flag : any_flag;

        if (capture) begin
            state_d = HEADER;
            cnt_d   = '0;
            carry_d = 1'b0;
            if (Arith_Flag) begin
                src_d   = SRC_ARITH;
                carry_d = Carry_OUT;
                data_d  = Arith_OUT;
            end else if (Logic_Flag) begin
                src_d  = SRC_LOGIC;
                data_d = ARITH_WIDTH'(Logic_OUT);
            end else if (CMP_Flag) begin
                src_d  = SRC_CMP;
                data_d = ARITH_WIDTH'(CMP_OUT);
            end else begin
                src_d  = SRC_SHIFT;
                data_d = ARITH_WIDTH'(Shift_OUT);
            end
        end else begin
            case (state_q)
                HEADER: begin
                    if (xfer) begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (last_xfer) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (xfer) begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = data_q >> 8;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            carry_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            carry_q <= carry_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        case (state_q)
            HEADER:  TX_DATA = {4'hA, src_q, carry_q, 1'b0};
            PAYLOAD: TX_DATA = data_q[7:0];
            default: TX_DATA = 8'h00;
        endcase
    end

    assign TX_VALID  = (state_q != IDLE);
    assign Busy      = (state_q != IDLE);
    assign Drop_Flag = drop_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

    logic        CLK;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT;
    logic        Arith_Flag;
    logic [15:0] Logic_OUT;
    logic        Logic_Flag;
    logic [15:0] Shift_OUT;
    logic        Shift_Flag;
    logic [2:0]  CMP_OUT;
    logic        CMP_Flag;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        Busy;
    logic        Drop_Flag;

    alu_result_serializer #(.OP_DATA_WIDTH(16), .ARITH_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .Busy(Busy), .Drop_Flag(Drop_Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] val;
        logic        carry;
        int          n;
        logic [39:0] exp;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         drop_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_flags();
        Arith_Flag = 1'b0;
        Logic_Flag = 1'b0;
        Shift_Flag = 1'b0;
        CMP_Flag   = 1'b0;
    endtask

    task automatic push_bytes(input logic [39:0] b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (Busy && k < 50) begin
            step();
            k++;
        end
        chk(name, {31'd0, Busy}, 32'd0);
    endtask

    // Drive one vector: unselected inputs get noise so selection is exercised.
    task automatic drive_vec(input vec_t v);
        Arith_OUT = $urandom;
        Logic_OUT = 16'($urandom);
        Shift_OUT = 16'($urandom);
        CMP_OUT   = 3'($urandom);
        Carry_OUT = v.carry;
        case (v.src)
            2'b00: begin Arith_OUT = v.val;       Arith_Flag = 1'b1; end
            2'b01: begin Logic_OUT = v.val[15:0]; Logic_Flag = 1'b1; end
            2'b10: begin CMP_OUT   = v.val[2:0];  CMP_Flag   = 1'b1; end
            default: begin Shift_OUT = v.val[15:0]; Shift_Flag = 1'b1; end
        endcase
        push_bytes(v.exp, v.n);
    endtask

    // Scoreboard: every accepted byte is popped and compared.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (RST) begin
            if (Drop_Flag) drop_cnt++;
            if (stall_prev && TX_VALID) chk("tx_stable", {24'd0, TX_DATA}, {24'd0, held});
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_byte: got %h expected none (t=%0t)", TX_DATA, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, TX_DATA}, {24'd0, e});
                end
            end
            stall_prev = TX_VALID && !TX_READY;
            held       = TX_DATA;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{2'b00, 32'h12345678, 1'b1, 5, 40'h12345678A2};
        vecs[1] = '{2'b00, 32'h000000FF, 1'b0, 5, 40'h000000FFA0};
        vecs[2] = '{2'b00, 32'hFFFFFFFF, 1'b1, 5, 40'hFFFFFFFFA2};
        vecs[3] = '{2'b01, 32'h0000BEEF, 1'b1, 3, 40'h0000BEEFA4};
        vecs[4] = '{2'b01, 32'h00000000, 1'b0, 3, 40'h00000000A4};
        vecs[5] = '{2'b11, 32'h000000F0, 1'b0, 3, 40'h000000F0AC};
        vecs[6] = '{2'b11, 32'h0000A55A, 1'b1, 3, 40'h0000A55AAC};
        vecs[7] = '{2'b10, 32'h00000002, 1'b0, 2, 40'h00000002A8};
        vecs[8] = '{2'b10, 32'h00000007, 1'b1, 2, 40'h00000007A8};
        vecs[9] = '{2'b10, 32'h00000000, 1'b0, 2, 40'h00000000A8};

        RST = 1'b0;
        TX_READY = 1'b1;
        Arith_OUT = 32'h0; Carry_OUT = 1'b0; Logic_OUT = 16'h0;
        Shift_OUT = 16'h0; CMP_OUT = 3'h0;
        clear_flags();

        // Reset with flags held high: nothing may be captured.
        Arith_OUT = 32'hCAFE0001; Carry_OUT = 1'b1; Arith_Flag = 1'b1; Logic_Flag = 1'b1;
        repeat (3) step();
        chk("rst_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rst_data", {24'd0, TX_DATA}, 32'h00);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_drop", {31'd0, Drop_Flag}, 32'd0);

        // First edge with RST high captures.
        Logic_Flag = 1'b0;
        RST = 1'b1;
        push_bytes(40'hCAFE0001A2, 5);
        step();
        chk("first_capture_valid", {31'd0, TX_VALID}, 32'd1);
        chk("first_capture_hdr", {24'd0, TX_DATA}, 32'hA2);
        clear_flags();
        wait_idle("first_frame_idle");

        // Table-driven single frames.
        for (int i = 0; i < 10; i++) begin
            d0 = drop_cnt;
            drive_vec(vecs[i]);
            step();
            chk("vec_latency_valid", {31'd0, TX_VALID}, 32'd1);
            chk("vec_latency_hdr", {24'd0, TX_DATA}, {24'd0, vecs[i].exp[7:0]});
            chk("vec_busy", {31'd0, Busy}, 32'd1);
            clear_flags();
            wait_idle("vec_idle");
            chk("vec_queue_empty", exp_q.size(), 32'd0);
            chk("vec_no_drop", drop_cnt, d0);
            step();
        end

        // Backpressure: header held stable for 5 cycles.
        CMP_OUT = 3'b010; CMP_Flag = 1'b1; TX_READY = 1'b0;
        push_bytes(40'h02A8, 2);
        step();
        clear_flags();
        for (int i = 0; i < 5; i++) begin
            chk("stall_hdr", {24'd0, TX_DATA}, 32'hA8);
            chk("stall_valid", {31'd0, TX_VALID}, 32'd1);
            if (i < 4) step();
        end
        TX_READY = 1'b1;
        wait_idle("stall_idle");
        chk("stall_queue_empty", exp_q.size(), 32'd0);

        // Arith and Shift together, then Shift during the frame.
        d0 = drop_cnt;
        Arith_OUT = 32'h12345678; Carry_OUT = 1'b1; Arith_Flag = 1'b1;
        Shift_OUT = 16'h1111; Shift_Flag = 1'b1;
        push_bytes(40'h12345678A2, 5);
        step();
        chk("coll_drop_pulse", {31'd0, Drop_Flag}, 32'd1);
        chk("coll_hdr", {24'd0, TX_DATA}, 32'hA2);
        clear_flags();
        step();
        chk("coll_drop_end", {31'd0, Drop_Flag}, 32'd0);
        Shift_Flag = 1'b1;
        step();
        chk("busy_drop_pulse", {31'd0, Drop_Flag}, 32'd1);
        clear_flags();
        step();
        chk("busy_drop_end", {31'd0, Drop_Flag}, 32'd0);
        wait_idle("coll_idle");
        chk("coll_queue_empty", exp_q.size(), 32'd0);
        chk("coll_drop_count", drop_cnt, d0 + 2);

        // Reset right after the header transfer.
        Arith_OUT = 32'h87654321; Carry_OUT = 1'b0; Arith_Flag = 1'b1;
        push_bytes(40'hA0, 1);
        step();
        clear_flags();
        step();
        RST = 1'b0;
        step();
        chk("midrst_valid", {31'd0, TX_VALID}, 32'd0);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_data", {24'd0, TX_DATA}, 32'h00);
        RST = 1'b1;
        step();
        step();
        chk("midrst_no_payload", exp_q.size(), 32'd0);
        chk("midrst_stays_idle", {31'd0, TX_VALID}, 32'd0);

        // Back-to-back: Shift captured on the last Logic payload edge.
        d0 = drop_cnt;
        Logic_OUT = 16'hBEEF; Logic_Flag = 1'b1;
        push_bytes(40'hBEEFA4, 3);
        step();
        clear_flags();
        step();
        step();
        Shift_OUT = 16'h00F0; Shift_Flag = 1'b1;
        push_bytes(40'h00F0AC, 3);
        step();
        clear_flags();
        chk("b2b_valid", {31'd0, TX_VALID}, 32'd1);
        chk("b2b_hdr", {24'd0, TX_DATA}, 32'hAC);
        chk("b2b_no_drop", {31'd0, Drop_Flag}, 32'd0);
        wait_idle("b2b_idle");
        chk("b2b_queue_empty", exp_q.size(), 32'd0);
        chk("b2b_drop_count", drop_cnt, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
